fsm: RTL and testbench
======================

# fsm

Moore-style control FSM that arms on a single-cycle trigger on `x`, runs a bounded 4-bit count, then reports completion for one cycle. State is visible on the 2-bit `z` output and progress on `counter`. It serves as a small sequencing block that downstream logic polls via `z`/`counter`.

## Interface
Parameters:
- `COUNT_MAX`, default 4'd5, terminal count of the COUNT phase (legal 0..15).

Ports (positional order is clk, x, z, rst, counter):
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: one clock; reset is asynchronous and active-low.
- `x` input 1: trigger/retrigger input, sampled on rising `clk`.
- `z` output 2: current state encoding, registered.
- `counter` output 4: count register, registered.

## Operation
- States and `z` encoding: IDLE=2'b00, ARM=2'b01, COUNT=2'b10, DONE=2'b11; `z` equals the state register directly.
- IDLE: `counter`=0. If `x`=1, go to ARM; else stay in IDLE. An unknown `x` is never sampled outside reset; RTL need not handle X.
- ARM: `counter`=0. Go to COUNT unconditionally; `x` is ignored.
- COUNT: entered with `counter`=0.
  - If `counter`==COUNT_MAX, go to DONE and hold `counter`.
  - Else `counter` <= `counter`+1 and stay in COUNT.
  - COUNT lasts COUNT_MAX+1 cycles.
- DONE: `counter` holds COUNT_MAX. Go to IDLE unconditionally and clear `counter` to 0. `x`=1 in DONE does not re-arm.
- Counter arithmetic is 4-bit unsigned. Wrap-around is impossible because COUNT stops at COUNT_MAX≤15.
- COUNT_MAX=0: COUNT lasts one cycle with `counter`=0, then DONE.
- Illegal state encodings do not exist, since all 4 encodings are used.

## Timing
- Reset (`rst`=0): `z`=2'b00, `counter`=4'd0, state IDLE. Takes effect immediately, without waiting for a clock edge.
- Reset is effective mid-operation from any state. Deassertion is synchronised externally; the first edge after release evaluates IDLE.
- `x`=1 sampled at edge k gives:
  - `z`=01 after edge k.
  - `z`=10 with `counter`=0 after edge k+1.
  - `counter`=n after edge k+1+n.
  - `z`=11 after edge k+2+COUNT_MAX.
  - `z`=00 with `counter`=0 after edge k+3+COUNT_MAX.
- Default latency from trigger to DONE is 7 edges.
- Outputs change only on the clock or on async reset. No combinational path from `x` to outputs.

## Configuration
- Macro: `FSM_RETRIGGER_EN`.
- Defined: `x`=1 sampled in COUNT resets `counter` to 0 and stays in COUNT. This takes priority over the terminal-count check.
- Undefined: `x` is ignored in every state except IDLE.

## Structure
- Shared package `fsm_pkg`:
  - state enum `fsm_state_t` with the encodings above;
  - constant `FSM_CNT_W`=4;
  - default `FSM_COUNT_MAX`=4'd5.
- One sub-module is natural: `fsm_counter`, a 4-bit counter with clear, enable and terminal-count compare, reset async active-low. The FSM top holds the state register and next-state logic.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `x`=0 -> `z`=00, `counter`=0 throughout, including asynchronously mid-cycle.
- Basic run: `x`=1 for one cycle, then 0 -> `z` sequence 01, 10×6 (`counter` 0,1,2,3,4,5), 11 (`counter`=5), then 00 (`counter`=0) and stays IDLE.
- Re-arm: `x`=1 held continuously -> after DONE returns to IDLE, next edge goes to ARM, giving a period of 9 cycles.
- Mid-run reset: assert `rst`=0 while `z`=10 and `counter`=3 -> immediately `z`=00, `counter`=0; after release, IDLE until `x`=1.
- Retrigger (`FSM_RETRIGGER_EN` defined): `x`=1 when `counter`=3 in COUNT -> next `counter`=0, `z`=10; DONE occurs 6 cycles later. Undefined: the same stimulus has no effect.
- COUNT_MAX=0: trigger -> 01, 10 (`counter`=0) for 1 cycle, 11, 00.

Source files
------------

// File: rtl/fsm_pkg.sv
// fsm_pkg: shared types and constants for the fsm sequencing block.
//   fsm_state_t   - state encoding, also driven straight onto the z output
//   FSM_CNT_W     - width of the progress counter
//   FSM_COUNT_MAX - default terminal count of the COUNT phase
package fsm_pkg;

  localparam int FSM_CNT_W = 4;

  localparam logic [FSM_CNT_W-1:0] FSM_COUNT_MAX = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARM   = 2'b01,
    COUNT = 2'b10,
    DONE  = 2'b11
  } fsm_state_t;

endpackage

// File: rtl/fsm_counter.sv
// fsm_counter: 4-bit progress counter with synchronous clear, count enable
// and a terminal-count flag.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous reset, active low; clears the count
//   clear  - synchronous clear to zero (wins over enable)
//   enable - increment by one on the next rising edge
//   count  - registered count value
//   at_max - high while count equals COUNT_MAX
module fsm_counter
  import fsm_pkg::*;
#(
  parameter logic [FSM_CNT_W-1:0] COUNT_MAX = FSM_COUNT_MAX
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  output logic [FSM_CNT_W-1:0] count,
  output logic                 at_max
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign at_max = (count == COUNT_MAX);

endmodule

// File: rtl/fsm.sv
// fsm: Moore control FSM. A single-cycle trigger on x arms the block, it then
// counts 0..COUNT_MAX in COUNT, shows DONE for one cycle and returns to IDLE.
// Ports:
//   clk     - clock, rising edge
//   x       - trigger (and retrigger when enabled), sampled on rising clk
//   z       - registered state encoding (IDLE=00, ARM=01, COUNT=10, DONE=11)
//   rst     - asynchronous reset, active low
//   counter - registered progress count
// Build option:
//   FSM_RETRIGGER_EN - when defined, x=1 during COUNT restarts the count at 0
//                      (this beats the terminal-count exit); otherwise x is
//                      only looked at in IDLE.
module fsm
  import fsm_pkg::*;
#(
  parameter logic [FSM_CNT_W-1:0] COUNT_MAX = FSM_COUNT_MAX
) (
  input  logic                 clk,
  input  logic                 x,
  output logic [1:0]           z,
  input  logic                 rst,
  output logic [FSM_CNT_W-1:0] counter
);

  fsm_state_t state;
  logic       retrig;
  logic       cnt_clear;
  logic       cnt_enable;
  logic       at_max;

`ifdef FSM_RETRIGGER_EN
  assign retrig = (state == COUNT) && x;
`else
  assign retrig = 1'b0;
`endif

  // The counter is held at zero outside COUNT, so it is already 0 when COUNT
  // is entered; leaving DONE clears it back to 0 on the same edge.
  assign cnt_clear  = (state != COUNT) || retrig;
  assign cnt_enable = (state == COUNT) && !at_max;

  fsm_counter #(
    .COUNT_MAX(COUNT_MAX)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .enable(cnt_enable),
    .count (counter),
    .at_max(at_max)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (x) state <= ARM;
        ARM:     state <= COUNT;
        COUNT: begin
          if (retrig) begin
            state <= COUNT;
          end else if (at_max) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign z = state;

endmodule

// File: tb/tb_fsm.sv
// tb_fsm: self-checking bench for fsm. Two instances run side by side, one
// with the default terminal count (5) and one with COUNT_MAX=0. A timeline
// model (edges elapsed since the accepted trigger) predicts z/counter and is
// compared on every falling clock edge; directed literal checks pin the model.
// Build option honoured: FSM_RETRIGGER_EN.
module tb_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       x;
  logic [1:0] z0, z1;
  logic [3:0] c0, c1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fsm #(.COUNT_MAX(4'd5)) dut0 (
    .clk    (clk),
    .x      (x),
    .z      (z0),
    .rst    (rst),
    .counter(c0)
  );

  fsm #(.COUNT_MAX(4'd0)) dut1 (
    .clk    (clk),
    .x      (x),
    .z      (z1),
    .rst    (rst),
    .counter(c1)
  );

  // Timeline model: a run is described only by the number of edges since the
  // trigger edge (d). d=0 ARM, d=1..1+cm COUNT with counter d-1, d=2+cm DONE,
  // anything later is IDLE again.
  int cm[2]     = '{5, 0};
  bit active[2] = '{1'b0, 1'b0};
  int d[2]      = '{0, 0};
  bit cmp_en    = 1'b0;

  function automatic logic [5:0] modelOut(int i);
    if (!active[i] || d[i] >= 3 + cm[i]) return 6'h00;
    if (d[i] == 0) return {2'b01, 4'd0};
    if (d[i] <= 1 + cm[i]) return {2'b10, 4'(d[i] - 1)};
    return {2'b11, 4'(cm[i])};
  endfunction

  // Advance the model on each clock edge; reset clears it at once.
  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        active[i] = 1'b0;
        d[i]      = 0;
      end else if (!active[i] || d[i] >= 3 + cm[i]) begin
        if (x) begin
          active[i] = 1'b1;
          d[i]      = 0;
        end
      end else begin
`ifdef FSM_RETRIGGER_EN
        if (x && d[i] >= 1 && d[i] <= 1 + cm[i]) d[i] = 1;
        else d[i] = d[i] + 1;
`else
        d[i] = d[i] + 1;
`endif
      end
    end
  end

  task automatic checkOutput(input string name, input logic [5:0] got,
                             input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got z=%b counter=%0d, expected z=%b counter=%0d",
               name, $time, got[5:4], got[3:0], exp[5:4], exp[3:0]);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("model_cm5", {z0, c0}, modelOut(0));
      checkOutput("model_cm0", {z1, c1}, modelOut(1));
    end
  end

  // Wait for the next rising edge, then drive new inputs 2 time units later.
  task automatic applyStimulus(input logic xv, input logic rv);
    @(posedge clk);
    #2;
    x   = xv;
    rst = rv;
  endtask

  logic [5:0] basic0[9] = '{6'h10, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h35, 6'h00};
  logic [5:0] basic1[9] = '{6'h10, 6'h20, 6'h30, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  initial begin
    int last;
    int ntrig;

    $display("[TB] start");
    x   = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    checkOutput("reset_async_cm5", {z0, c0}, 6'h00);
    checkOutput("reset_async_cm0", {z1, c1}, 6'h00);
    cmp_en = 1'b1;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    #1;
    checkOutput("reset_held", {z0, c0}, 6'h00);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    #1;
    checkOutput("idle_after_release", {z0, c0}, 6'h00);

    // Basic run: single-cycle trigger.
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    #1;
    checkOutput("basic_cm5_0", {z0, c0}, basic0[0]);
    checkOutput("basic_cm0_0", {z1, c1}, basic1[0]);
    for (int i = 1; i < 9; i++) begin
      applyStimulus(1'b0, 1'b1);
      #1;
      checkOutput($sformatf("basic_cm5_%0d", i), {z0, c0}, basic0[i]);
      checkOutput($sformatf("basic_cm0_%0d", i), {z1, c1}, basic1[i]);
    end

    // Re-arm: x held high, triggers repeat every 9 edges for COUNT_MAX=5.
    last  = -1;
    ntrig = 0;
    for (int i = 0; i < 22; i++) begin
      applyStimulus(1'b1, 1'b1);
      #1;
      if (z0 == 2'b01) begin
        if (last >= 0) checkValue("rearm_period", i - last, 9);
        last = i;
        ntrig++;
      end
    end
    checkValue("rearm_triggers", ntrig, 3);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1);

    // Mid-run reset while counter=3.
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1);
    #1;
    checkOutput("midrun_before", {z0, c0}, 6'h23);
    rst = 1'b0;
    #1;
    checkOutput("midrun_async_cm5", {z0, c0}, 6'h00);
    checkOutput("midrun_async_cm0", {z1, c1}, 6'h00);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1);
      #1;
      checkOutput("midrun_idle", {z0, c0}, 6'h00);
    end

    // Retrigger pulse while counter=3.
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    #1;
`ifdef FSM_RETRIGGER_EN
    checkOutput("retrig_restart", {z0, c0}, 6'h20);
`else
    checkOutput("retrig_ignored", {z0, c0}, 6'h24);
`endif
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1);
    #1;
`ifdef FSM_RETRIGGER_EN
    checkOutput("retrig_done", {z0, c0}, 6'h35);
`else
    checkOutput("retrig_idle", {z0, c0}, 6'h00);
`endif
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
